// File: rtl/ram8_sweep_if.sv
// ram8_sweep_if: read/write/clear bus of the 8-word RAM with sweep clear.
interface ram8_sweep_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] in;
    logic [2:0]       address;
    logic             load;
    logic             clr;
    logic [WIDTH-1:0] out;
    logic             busy;
    modport master(output in, address, load, clr, input out, busy);
    modport slave(input in, address, load, clr, output out, busy);
endinterface

// File: rtl/ram8_sweep.sv
// ram8_sweep: 8-word register file with combinational read and an 8-cycle sequential clear sweep.
module ram8_sweep #(
    parameter int WIDTH = 16
) (
    input logic         clk,
    input logic         rst_n,
    ram8_sweep_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;
    logic [WIDTH-1:0] mem [8];
    logic [0:0]       state;
    logic [2:0]       ptr;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
            state <= IDLE;
            ptr   <= '0;
        end else if (state == IDLE) begin
            if (bus.load) mem[bus.address] <= bus.in;
            if (bus.clr) begin
                state <= SWEEP;
                ptr   <= '0;
            end
        end else begin
            // load and clr are ignored here; the sweep runs word 0..7 regardless of address
            mem[ptr] <= '0;
            ptr      <= ptr + 3'd1;
            if (ptr == 3'd7) state <= IDLE;
        end
    end
    assign bus.out  = mem[bus.address];
    assign bus.busy = (state == SWEEP);
endmodule
